l5_apical_plateau: RTL and testbench

Layer-5 pyramidal dendritic stage, directly downstream of the L1 apical-gain block. It scales basal (feedforward) drive by the SST+-filtered apical_gain. A coincidence-triggered calcium-plateau state machine (BAC-style) adds a fixed boost to somatic drive for a bounded window, then enforces a refractory period. Its output soma_drive feeds the L5 oscillator/spike stage. All arithmetic is Q4.14 signed.

---
 rtl/l5_apical_plateau.sv | 151 +++++++++++++++
 tb/tb_l5_apical_plateau.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/l5_apical_plateau.sv
// Layer-5 pyramidal dendritic stage: apical-gain scaling of basal drive plus a
// coincidence-triggered calcium plateau (boost window followed by refractory).
module l5_apical_plateau #(
    parameter int                        WIDTH          = 18,
    parameter int                        FRAC           = 14,
    parameter logic signed [WIDTH-1:0]   CA_THRESH      = 18'sd8192,
    parameter logic signed [WIDTH-1:0]   BASAL_THRESH   = 18'sd4096,
    parameter logic signed [WIDTH-1:0]   PLATEAU_BOOST  = 18'sd8192,
    parameter int                        PLATEAU_CYCLES = 20,
    parameter int                        REFRACT_CYCLES = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] basal_input,
    input  logic signed [WIDTH-1:0] apical_input,
    input  logic signed [WIDTH-1:0] apical_gain,
    output logic signed [WIDTH-1:0] soma_drive,
    output logic                    plateau_active,
    output logic                    plateau_start,
    output logic [7:0]              burst_count
);

    localparam int MAX_CYCLES = (PLATEAU_CYCLES > REFRACT_CYCLES) ? PLATEAU_CYCLES : REFRACT_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLATEAU = 2'd1,
        ST_REFRACT = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   next_state_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [CNT_W-1:0]         cnt_next_s;
    logic signed [WIDTH-1:0]  soma_r;
    logic                     active_r;
    logic                     start_r;
    logic [7:0]               burst_r;

    logic signed [2*WIDTH-1:0] prod_s;
    logic signed [2*WIDTH-1:0] shifted_s;
    logic signed [WIDTH-1:0]   gained_s;
    logic signed [WIDTH:0]     boost_s;
    logic signed [WIDTH:0]     sum_s;
    logic signed [WIDTH-1:0]   soma_next_s;
    logic                      trigger_s;

    // Clamp a double-width signed value into the WIDTH-bit signed range.
    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [2*WIDTH-1:0] v);
        logic signed [2*WIDTH-1:0] max_w;
        logic signed [2*WIDTH-1:0] min_w;
        max_w = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
        min_w = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
        if (v > max_w) begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end else if (v < min_w) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return v[WIDTH-1:0];
        end
    endfunction

    // Gain path, trigger detection and boosted somatic sum.
    always_comb begin
        prod_s    = $signed({{WIDTH{basal_input[WIDTH-1]}}, basal_input}) *
                    $signed({{WIDTH{apical_gain[WIDTH-1]}}, apical_gain});
        shifted_s = prod_s >>> FRAC;
        gained_s  = sat_w(shifted_s);
        trigger_s = (apical_input >= CA_THRESH) && (gained_s >= BASAL_THRESH);
        if (next_state_s == ST_PLATEAU) begin
            boost_s = {PLATEAU_BOOST[WIDTH-1], PLATEAU_BOOST};
        end else begin
            boost_s = '0;
        end
        sum_s       = {gained_s[WIDTH-1], gained_s} + boost_s;
        soma_next_s = sat_w({{(WIDTH-1){sum_s[WIDTH]}}, sum_s});
    end

    // Plateau FSM next-state and counter logic.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    next_state_s = ST_PLATEAU;
                    cnt_next_s   = CNT_W'(PLATEAU_CYCLES - 1);
                end else begin
                    next_state_s = ST_IDLE;
                    cnt_next_s   = cnt_r;
                end
            end
            ST_PLATEAU: begin
                if (cnt_r == '0) begin
                    next_state_s = ST_REFRACT;
                    cnt_next_s   = CNT_W'(REFRACT_CYCLES - 1);
                end else begin
                    next_state_s = ST_PLATEAU;
                    cnt_next_s   = cnt_r - 1'b1;
                end
            end
            ST_REFRACT: begin
                if (cnt_r == '0) begin
                    next_state_s = ST_IDLE;
                    cnt_next_s   = '0;
                end else begin
                    next_state_s = ST_REFRACT;
                    cnt_next_s   = cnt_r - 1'b1;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; the start pulse self-clears every clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            soma_r   <= '0;
            active_r <= 1'b0;
            start_r  <= 1'b0;
            burst_r  <= 8'd0;
        end else begin
            start_r <= 1'b0;
            if (clk_en) begin
                state_r  <= next_state_s;
                cnt_r    <= cnt_next_s;
                soma_r   <= soma_next_s;
                active_r <= (next_state_s == ST_PLATEAU);
                if ((state_r == ST_IDLE) && (next_state_s == ST_PLATEAU)) begin
                    start_r <= 1'b1;
                    if (burst_r != 8'd255) begin
                        burst_r <= burst_r + 8'd1;
                    end
                end
            end
        end
    end

    assign soma_drive     = soma_r;
    assign plateau_active = active_r;
    assign plateau_start  = start_r;
    assign burst_count    = burst_r;

endmodule

// File: tb/tb_l5_apical_plateau.sv
// Scoreboard bench for l5_apical_plateau: a sample-indexed plateau model pushes
// expected outputs per clock; a monitor pops and compares after each edge.
module tb_l5_apical_plateau;

    localparam int P = 20;
    localparam int R = 40;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clk_en = 1'b0;
    logic signed [17:0] basal_input = '0;
    logic signed [17:0] apical_input = '0;
    logic signed [17:0] apical_gain = '0;
    logic signed [17:0] soma_drive;
    logic               plateau_active;
    logic               plateau_start;
    logic [7:0]         burst_count;

    l5_apical_plateau dut (
        .clk            (clk),
        .rst            (rst),
        .clk_en         (clk_en),
        .basal_input    (basal_input),
        .apical_input   (apical_input),
        .apical_gain    (apical_gain),
        .soma_drive     (soma_drive),
        .plateau_active (plateau_active),
        .plateau_start  (plateau_start),
        .burst_count    (burst_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int soma;
        bit act;
        bit st;
        int burst;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    // Model: sample index, earliest sample allowed to trigger, last plateau start.
    longint n_m = 0;
    longint idle_from_m = 0;
    longint start_m = -1000000;
    int     burst_m = 0;
    int     soma_m = 0;
    bit     act_m = 0;

    function automatic int sat18(longint v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return int'(v);
    endfunction

    task automatic step(input bit en, input int b, input int a, input int g);
        exp_t e;
        longint prod;
        int gained;
        bit st;
        @(negedge clk);
        clk_en = en;
        basal_input = 18'(b);
        apical_input = 18'(a);
        apical_gain = 18'(g);
        st = 1'b0;
        if (en) begin
            prod = longint'(b) * longint'(g);
            gained = sat18(prod >>> 14);
            if (n_m >= idle_from_m && a >= 8192 && gained >= 4096) begin
                st = 1'b1;
                start_m = n_m;
                idle_from_m = n_m + P + R + 1;
                if (burst_m < 255) burst_m++;
            end
            act_m = (n_m >= start_m) && (n_m < start_m + P);
            soma_m = sat18(longint'(gained) + (act_m ? 8192 : 0));
            n_m++;
        end
        e.soma = soma_m; e.act = act_m; e.st = st; e.burst = burst_m;
        q.push_back(e);
    endtask

    task automatic run(input int cycles, input bit en, input int b, input int a, input int g);
        for (int i = 0; i < cycles; i++) step(en, b, a, g);
    endtask

    task automatic check_zero(input string name);
        compared++;
        if (soma_drive !== 18'sd0 || plateau_active !== 1'b0 || plateau_start !== 1'b0 || burst_count !== 8'd0) begin
            mismatched++;
            $display("FAIL %s: got soma=%0d act=%0b st=%0b burst=%0d, want all 0",
                     name, soma_drive, plateau_active, plateau_start, burst_count);
        end
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        clk_en = 1'b0;
        rst = 1'b1;
        #1 check_zero("async_reset");
        #1 rst = 1'b0;
        n_m = 0; idle_from_m = 0; start_m = -1000000; burst_m = 0; soma_m = 0; act_m = 0;
        e.soma = 0; e.act = 0; e.st = 0; e.burst = 0;
        q.push_back(e);
    endtask

    // Monitor: compare DUT outputs just after every active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                compared++;
                if (int'(soma_drive) != e.soma || plateau_active !== e.act ||
                    plateau_start !== e.st || int'(burst_count) != e.burst) begin
                    mismatched++;
                    $display("FAIL outputs@%0t: got soma=%0d act=%0b st=%0b burst=%0d, want soma=%0d act=%0b st=%0b burst=%0d",
                             $time, soma_drive, plateau_active, plateau_start, burst_count,
                             e.soma, e.act, e.st, e.burst);
                end
            end
        end
    end

    initial begin
        int b, a, g, sel;
        #1 check_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;
        // Gain path without trigger
        run(3, 1, 8192, 0, 24576);
        run(2, 1, 8192, 0, 8192);
        // Saturation
        run(2, 1, 131071, 0, 24576);
        run(2, 1, -131072, 0, 24576);
        // Apical threshold edge, then a full plateau/refractory pair
        run(3, 1, 16384, 8191, 16384);
        run(130, 1, 16384, 16384, 16384);
        run(61, 1, 0, 0, 16384);
        // Basal threshold edge
        run(3, 1, 4095, 16384, 16384);
        run(1, 1, 4096, 16384, 16384);
        run(61, 1, 0, 0, 16384);
        // Saturated plateau, then clk_en low with churning inputs
        run(5, 1, 131071, 16384, 24576);
        for (int i = 0; i < 100; i++)
            step(1'b0, int'($urandom_range(0, 262143)) - 131072, 16384, int'($urandom_range(0, 262143)) - 131072);
        run(3, 1, 131071, 16384, 24576);
        // Reset mid-plateau
        run(61, 1, 0, 0, 0);
        run(6, 1, 16384, 16384, 16384);
        do_reset();
        run(3, 1, 16384, 16384, 16384);
        run(61, 1, 0, 0, 0);
        // Negative gain never triggers
        run(8, 1, 16384, 131071, -16384);
        // Randomized, biased toward thresholds
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 3));
            if (sel == 0) begin
                b = int'($urandom_range(4090, 4100)); g = 16384; a = int'($urandom_range(8188, 8196));
            end else begin
                b = int'($urandom_range(0, 262143)) - 131072;
                g = int'($urandom_range(0, 49152)) - 16384;
                a = int'($urandom_range(0, 32768)) - 8192;
            end
            step(($urandom_range(0, 3) != 0), b, a, g);
        end
        // Continuous triggering saturates burst_count
        run(300 * (P + R + 1) + 5, 1, 16384, 16384, 16384);
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
